// File: rtl/rom_sdram_loader.sv
// Packs the system ROM byte stream into 16-bit little-endian words and writes them to the SDRAM loader port.
// Optional LOADER_CHECKSUM_EN adds a 16-bit running byte sum output.
module rom_sdram_loader #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   rom_size,
  output logic              load_done,
  output logic              overflow,
  output logic              busy
`ifdef LOADER_CHECKSUM_EN
  , output logic [15:0]     checksum
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]     CNT_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0]   PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t            state, state_nx;
  entry_t            fifo_mem [FIFO_DEPTH];
  entry_t            head, push_entry;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [ADDR_W:0]   addr_cnt;
  logic              pend_vld;
  logic [7:0]        pend_byte;

  logic byte_in, pop, room, addr_ovf, start;
  logic push, take_even, drop_pair, drop_byte, flush_done;

  assign byte_in  = (state == LOAD) && rom_loading && rom_do_valid;
  assign pop      = mem_req && mem_ack;
  assign room     = (count != DEPTH_C) || pop;
  assign addr_ovf = addr_cnt[ADDR_W];
  assign start    = (state == IDLE) && rom_loading;
  assign head     = fifo_mem[rd_ptr];

  // The last entry popping this cycle counts as empty so load_done lines up with the ack.
  assign flush_done = !pend_vld && ((count == '0) || ((count == CNT_ONE) && pop));

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    take_even  = 1'b0;
    drop_pair  = 1'b0;
    drop_byte  = 1'b0;
    if (byte_in) begin
      if (addr_ovf)
        drop_byte = 1'b1;
      else if (!pend_vld)
        take_even = 1'b1;
      else if (!room)
        drop_pair = 1'b1;  // the held even byte goes with its partner
      else begin
        push       = 1'b1;
        push_entry = '{addr: addr_cnt[ADDR_W-1:0], data: {rom_do, pend_byte}, be: 2'b11};
      end
    end else if ((state == FLUSH) && pend_vld && room) begin
      push       = 1'b1;
      push_entry = '{addr: addr_cnt[ADDR_W-1:0], data: {8'h00, pend_byte}, be: 2'b01};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (rom_loading)  state_nx = LOAD;
      LOAD:    if (!rom_loading) state_nx = FLUSH;
      FLUSH:   if (flush_done)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      addr_cnt  <= '0;
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      rom_size  <= '0;
      overflow  <= 1'b0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_be    <= '0;
    end else begin
      load_done <= (state == FLUSH) && (state_nx == IDLE);
      busy      <= (state_nx != IDLE);

      if (start) begin
        addr_cnt <= '0;
        rom_size <= '0;
        pend_vld <= 1'b0;
        overflow <= 1'b0;
      end
      if (take_even) begin
        pend_vld  <= 1'b1;
        pend_byte <= rom_do;
        rom_size  <= rom_size + ONE;
      end
      if (push) begin
        pend_vld <= 1'b0;
        addr_cnt <= addr_cnt + ONE;
        if (byte_in) rom_size <= rom_size + ONE;
      end
      if (drop_pair) begin
        pend_vld <= 1'b0;
        rom_size <= rom_size - ONE;
      end
      if (drop_pair || drop_byte) overflow <= 1'b1;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // Head is captured as req rises, so the bus stays stable until the ack.
      if (mem_req) begin
        if (mem_ack) mem_req <= 1'b0;
      end else if (count != '0) begin
        mem_req  <= 1'b1;
        mem_addr <= head.addr;
        mem_din  <= head.data;
        mem_be   <= head.be;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      checksum <= '0;
    else if (start)
      checksum <= '0;
    else if (take_even || (push && byte_in))
      checksum <= checksum + {8'h00, rom_do};
    else if (drop_pair)
      checksum <= checksum - {8'h00, pend_byte};
  end
`endif

endmodule

// File: tb/tb_rom_sdram_loader.sv
// Scoreboard bench for rom_sdram_loader: expected writes are queued from the byte list, a monitor checks each accepted write.
module tb_rom_sdram_loader;
  localparam int AW    = 22;
  localparam int DEPTH = 8;
  localparam int EW    = AW + 18;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rom_loading = 1'b0;
  logic [7:0]    rom_do = '0;
  logic          rom_do_valid = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_be;
  logic [AW:0]   rom_size;
  logic          load_done, overflow, busy;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  always #5 clk = ~clk;

  rom_sdram_loader #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_be(mem_be), .mem_ack(mem_ack), .rom_size(rom_size),
    .load_done(load_done), .overflow(overflow), .busy(busy)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int          vectors = 0, miscompares = 0;
  int          done_cnt = 0, wr_cnt = 0, cyc = 0, last_acc = 0;
  bit          ack_en = 1'b1;
  int          ack_lo = 0, ack_hi = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]  bq[$];
  logic [AW:0] exp_size = '0;
  logic [15:0] exp_sum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Controller model: ack after a random 0..N cycle delay once req is seen.
  initial begin
    int wcnt, dly;
    wcnt = 0; dly = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_req || !ack_en) wcnt = 0;
      else begin
        if (wcnt == 0) dly = $urandom_range(ack_hi, ack_lo);
        if (wcnt >= dly) begin mem_ack = 1'b1; wcnt = 0; end
        else wcnt++;
      end
    end
  end

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (load_done) done_cnt++;
      if (mem_req && mem_ack) begin
        wr_cnt++;
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL write_unexpected: got %0h expected none", {mem_addr, mem_din, mem_be});
        end else begin
          e = exp_q.pop_front();
          chk("write", {mem_addr, mem_din, mem_be}, e);
        end
      end
    end
  end

  // Reference: pairs of bytes form words in order; words past 'cap' are lost with their bytes.
  task automatic model_load(input int cap);
    int n, kept;
    n = bq.size(); kept = 0; exp_size = '0; exp_sum = '0;
    for (int i = 0; i + 1 < n; i += 2)
      if (kept < cap) begin
        exp_q.push_back({AW'(kept), bq[i+1], bq[i], 2'b11});
        kept++;
        exp_size = exp_size + 2;
        exp_sum  = exp_sum + bq[i] + bq[i+1];
      end
    if (n % 2 == 1) begin
      exp_q.push_back({AW'(kept), 8'h00, bq[n-1], 2'b01});
      exp_size = exp_size + 1;
      exp_sum  = exp_sum + bq[n-1];
    end
  endtask

  task automatic stream(input int gap_lo, input int gap_hi);
    for (int i = 0; i < bq.size(); i++) begin
      rom_do = bq[i]; rom_do_valid = 1'b1;
      @(posedge clk); #1;
      rom_do_valid = 1'b0;
      repeat ($urandom_range(gap_hi, gap_lo)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic begin_load();
    @(posedge clk); #1; rom_loading = 1'b1;
    @(posedge clk); #1;
    chk("busy_in_load", busy, 1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (load_done) begin ok = 1'b1; break; end
    end
    chk("load_done_seen", ok, 1);
  endtask

  task automatic end_checks(input bit exp_ovf);
    chk("rom_size", rom_size, exp_size);
    chk("overflow", overflow, exp_ovf);
    chk("writes_left", exp_q.size(), 0);
    chk("busy_at_done", busy, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", checksum, exp_sum);
`endif
  endtask

  task automatic run_load(input int gap_lo, input int gap_hi);
    int d0;
    model_load(1 << 30);
    d0 = done_cnt;
    begin_load();
    stream(gap_lo, gap_hi);
    rom_loading = 1'b0;
    wait_done();
    end_checks(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int d0, w0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_bus", {mem_addr, mem_din, mem_be}, 0);
    chk("rst_rom_size", rom_size, 0);
    chk("rst_flags", {load_done, overflow, busy}, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    resetn = 1'b1;

    // Directed five-byte load, ack one cycle into each request.
    ack_lo = 1; ack_hi = 1;
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    model_load(1 << 30);
    d0 = done_cnt;
    begin_load();
    rom_do = 8'h11; rom_do_valid = 1'b1; @(posedge clk); #1;
    rom_do = 8'h22; @(posedge clk); #1;
    chk("req_not_yet", mem_req, 0);
    rom_do = 8'h33; @(posedge clk); #1;
    chk("req_latency", mem_req, 1);
    chk("first_head", {mem_addr, mem_din, mem_be}, {AW'(0), 16'h2211, 2'b11});
    rom_do = 8'h44; @(posedge clk); #1;
    rom_do = 8'h55; @(posedge clk); #1;
    rom_do_valid = 1'b0; rom_loading = 1'b0;
    wait_done();
    chk("done_after_ack", cyc - last_acc, 1);
    end_checks(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);

    // Overflow: acks withheld while 20 bytes stream back to back.
    ack_en = 1'b0; ack_lo = 0; ack_hi = 2;
    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
    model_load(DEPTH);
    d0 = done_cnt;
    begin_load();
    stream(0, 0);
    rom_loading = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_flag", overflow, 1);
    chk("ovf_size", rom_size, 16);
    chk("ovf_req_stall", mem_req, 1);
    w0 = wr_cnt;
    ack_en = 1'b1;
    wait_done();
    end_checks(1'b1);
    chk("ovf_write_count", wr_cnt - w0, DEPTH);

`ifdef LOADER_CHECKSUM_EN
    bq = '{8'hFF, 8'hFF, 8'h02};
    run_load(0, 2);
    chk("checksum_wrap", checksum, 16'h0200);
`endif

    // Reset while a write is outstanding: it must be abandoned.
    ack_en = 1'b0;
    bq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    begin_load();
    stream(0, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_req", mem_req, 1);
    d0 = done_cnt;
    resetn = 1'b0; rom_loading = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_bus", {mem_addr, mem_din, mem_be}, 0);
    chk("mid_rst_size", rom_size, 0);
    chk("mid_rst_flags", {load_done, overflow, busy}, 0);
    ack_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_idle_req", mem_req, 0);

    // Back-to-back: load window reopens while the first load is still flushing.
    ack_lo = 2; ack_hi = 2;
    bq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    model_load(1 << 30);
    d0 = done_cnt;
    begin_load();
    stream(0, 0);
    rom_loading = 1'b0;
    @(posedge clk); #1;
    rom_loading = 1'b1;
    wait_done();
    end_checks(1'b0);
    bq = '{8'hAA, 8'hBB};
    model_load(1 << 30);
    @(posedge clk); #1;
    chk("b2b_busy", busy, 1);
    stream(0, 0);
    rom_loading = 1'b0;
    wait_done();
    end_checks(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // Strobes outside the load window are ignored.
    for (int i = 0; i < 4; i++) begin
      rom_do = 8'($urandom); rom_do_valid = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_req", mem_req, 0);
    end
    rom_do_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_no_req_late", mem_req, 0);
    chk("idle_size_kept", rom_size, exp_size);

    // Random loads at a rate the write path can sustain.
    ack_lo = 0; ack_hi = 2;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(14, 0);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      run_load(1, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
